// File: rtl/cu_cache_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cu_cache_request_arbiter
// Purpose  : Round-robin sharing of one compute-unit cache request port among
//            NUM_REQ engine requesters. Each issued request is tagged with its
//            requester ID. Responses are routed back by that tag. The number of
//            in-flight requests is capped so the cache response FIFO never
//            overflows.
// Revision : 1.0  initial release
// ============================================================================
module cu_cache_request_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int REQ_PAYLOAD_W   = 128,
  parameter int RSP_PAYLOAD_W   = 64,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_W           = 5
) (
  input  logic                             ap_clk,
  input  logic                             areset,
  // engine request side
  input  logic [NUM_REQ-1:0]               req_valid_in,
  input  logic [NUM_REQ*REQ_PAYLOAD_W-1:0] req_payload_in,
  output logic [NUM_REQ-1:0]               req_ready_out,
  // cache request FIFO side
  output logic                             cache_req_valid_out,
  output logic [REQ_PAYLOAD_W-1:0]         cache_req_payload_out,
  output logic [ID_W-1:0]                  cache_req_id_out,
  input  logic                             cache_prog_full_in,
  // cache response FIFO side
  input  logic                             cache_rsp_valid_in,
  input  logic [ID_W-1:0]                  cache_rsp_id_in,
  input  logic [RSP_PAYLOAD_W-1:0]         cache_rsp_payload_in,
  // engine response side
  output logic [NUM_REQ-1:0]               rsp_valid_out,
  output logic [RSP_PAYLOAD_W-1:0]         rsp_payload_out,
  // status
  output logic [CNT_W-1:0]                 outstanding_out,
  output logic                             error_out,
  output logic                             done_out
);

  localparam logic [CNT_W-1:0] c_MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [ID_W:0]    c_NUM_REQ   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  c_LAST_INIT = ID_W'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [ID_W-1:0]          r_last;
  logic [CNT_W-1:0]         r_outstanding;
  logic                     r_error;
  logic                     r_done;
  logic                     r_cache_req_valid;
  logic [REQ_PAYLOAD_W-1:0] r_cache_req_payload;
  logic [ID_W-1:0]          r_cache_req_id;
  logic [NUM_REQ-1:0]       r_rsp_valid;
  logic [RSP_PAYLOAD_W-1:0] r_rsp_payload;

  // --------------------------------------------------------------------------
  // Combinational arbitration signals
  // --------------------------------------------------------------------------
  logic                          w_issue_en;
  logic [NUM_REQ-1:0]            w_above_last;
  logic [NUM_REQ-1:0]            w_req_hi;
  logic [NUM_REQ-1:0]            w_pick;
  logic [NUM_REQ-1:0]            w_grant_hot;
  logic [ID_W-1:0][NUM_REQ-1:0]  w_id_term;
  logic [ID_W-1:0]               w_grant_id;
  logic [REQ_PAYLOAD_W-1:0]      w_payload_arr [NUM_REQ];
  logic                          w_xfer;
  logic                          w_rsp_id_ok;
  logic [NUM_REQ-1:0]            w_rsp_hot;

  // A free slot exists and the cache request FIFO is not pushing back.
  assign w_issue_en = ~cache_prog_full_in & (r_outstanding < c_MAX_OUT);

  // Per-requester helpers: priority mask, payload slices, response decode.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    localparam logic [ID_W:0]   c_IDX_W = (ID_W+1)'(i);
    localparam logic [ID_W-1:0] c_IDX   = ID_W'(i);
    assign w_above_last[i]  = c_IDX_W > {1'b0, r_last};
    assign w_payload_arr[i] = req_payload_in[i*REQ_PAYLOAD_W +: REQ_PAYLOAD_W];
    assign w_rsp_hot[i]     = (cache_rsp_id_in == c_IDX);
  end

  // Round robin: prefer requesters numbered above the last grant, otherwise
  // wrap to the lowest-numbered active requester. The lowest set bit of the
  // chosen vector is the grant.
  assign w_req_hi    = req_valid_in & w_above_last;
  assign w_pick      = (|w_req_hi) ? w_req_hi : req_valid_in;
  assign w_grant_hot = w_pick & (~w_pick + NUM_REQ'(1));

  // One-hot to binary: bit b of the ID is the OR of grant bits whose index has
  // bit b set.
  for (genvar b = 0; b < ID_W; b++) begin : g_idbit
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_term
      localparam logic c_SET = ((i >> b) & 1) == 1;
      assign w_id_term[b][i] = w_grant_hot[i] & c_SET;
    end
    assign w_grant_id[b] = |w_id_term[b];
  end

  assign req_ready_out = w_issue_en ? w_grant_hot : '0;
  assign w_xfer        = w_issue_en & (|req_valid_in);
  assign w_rsp_id_ok   = {1'b0, cache_rsp_id_in} < c_NUM_REQ;

  // Register the granted request towards the cache and advance the pointer.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_cache_req_valid   <= 1'b0;
      r_cache_req_payload <= '0;
      r_cache_req_id      <= '0;
      r_last              <= c_LAST_INIT;
    end else begin
      r_cache_req_valid <= w_xfer;
      if (w_xfer) begin
        r_cache_req_payload <= w_payload_arr[w_grant_id];
        r_cache_req_id      <= w_grant_id;
        r_last              <= w_grant_id;
      end
    end
  end

  // Route each cache response to its owner; unknown IDs are dropped.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_rsp_valid   <= '0;
      r_rsp_payload <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (cache_rsp_valid_in) begin
        r_rsp_payload <= cache_rsp_payload_in;
        if (w_rsp_id_ok) begin
          r_rsp_valid <= w_rsp_hot;
        end
      end
    end
  end

  // Track in-flight requests; a response with nothing in flight is an error.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_outstanding <= '0;
      r_error       <= 1'b0;
    end else begin
      case ({w_xfer, cache_rsp_valid_in})
        2'b10: r_outstanding <= r_outstanding + c_CNT_ONE;
        2'b01: begin
          if (r_outstanding == '0) begin
            r_error <= 1'b1;
          end else begin
            r_outstanding <= r_outstanding - c_CNT_ONE;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
      if (cache_rsp_valid_in && !w_rsp_id_ok) begin
        r_error <= 1'b1;
      end
    end
  end

  // Idle when nothing is in flight, pending, presented or returning.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_done <= 1'b1;
    end else begin
      r_done <= (r_outstanding == '0) & ~(|req_valid_in) &
                ~r_cache_req_valid & ~cache_rsp_valid_in;
    end
  end

  assign cache_req_valid_out   = r_cache_req_valid;
  assign cache_req_payload_out = r_cache_req_payload;
  assign cache_req_id_out      = r_cache_req_id;
  assign rsp_valid_out         = r_rsp_valid;
  assign rsp_payload_out       = r_rsp_payload;
  assign outstanding_out       = r_outstanding;
  assign error_out             = r_error;
  assign done_out              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cu_cache_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_cache_request_arbiter
// Purpose  : Directed scoreboard bench for cu_cache_request_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_cu_cache_request_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int RQW     = 128;
  localparam int RSW     = 64;
  localparam int MAXO    = 16;
  localparam int CNT_W   = 5;

  localparam logic [RQW-1:0] c_P0 = 128'h1111_0000;
  localparam logic [RQW-1:0] c_P1 = 128'h2222_0001;
  localparam logic [RQW-1:0] c_P2 = 128'hA5;
  localparam logic [RQW-1:0] c_P3 = 128'h4444_0003;

  logic                     ap_clk = 1'b0;
  logic                     areset = 1'b1;
  logic [NUM_REQ-1:0]       req_valid_in = '0;
  logic [NUM_REQ*RQW-1:0]   req_payload_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     cache_req_valid_out;
  logic [RQW-1:0]           cache_req_payload_out;
  logic [ID_W-1:0]          cache_req_id_out;
  logic                     cache_prog_full_in = 1'b0;
  logic                     cache_rsp_valid_in = 1'b0;
  logic [ID_W-1:0]          cache_rsp_id_in = '0;
  logic [RSW-1:0]           cache_rsp_payload_in = '0;
  logic [NUM_REQ-1:0]       rsp_valid_out;
  logic [RSW-1:0]           rsp_payload_out;
  logic [CNT_W-1:0]         outstanding_out;
  logic                     error_out;
  logic                     done_out;

  assign req_payload_in = {c_P3, c_P2, c_P1, c_P0};

  cu_cache_request_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .REQ_PAYLOAD_W(RQW), .RSP_PAYLOAD_W(RSW),
    .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .req_valid_in(req_valid_in),
    .req_payload_in(req_payload_in),
    .req_ready_out(req_ready_out),
    .cache_req_valid_out(cache_req_valid_out),
    .cache_req_payload_out(cache_req_payload_out),
    .cache_req_id_out(cache_req_id_out),
    .cache_prog_full_in(cache_prog_full_in),
    .cache_rsp_valid_in(cache_rsp_valid_in),
    .cache_rsp_id_in(cache_rsp_id_in),
    .cache_rsp_payload_in(cache_rsp_payload_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_payload_out(rsp_payload_out),
    .outstanding_out(outstanding_out),
    .error_out(error_out),
    .done_out(done_out)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [RQW-1:0]  pay;
  } req_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] hot;
    logic [RSW-1:0]     pay;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t e_req;
  rsp_t e_rsp;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [RQW-1:0] pay_of(int id);
    case (id)
      0:       return c_P0;
      1:       return c_P1;
      2:       return c_P2;
      default: return c_P3;
    endcase
  endfunction

  // Monitor: every presented output must match the next queued expectation.
  always @(negedge ap_clk) begin
    if (cache_req_valid_out) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got id %0d expected no request", cache_req_id_out);
      end else begin
        e_req = exp_req.pop_front();
        chk("req_id", {126'b0, cache_req_id_out}, {126'b0, e_req.id});
        chk("req_payload", cache_req_payload_out, e_req.pay);
      end
    end
    if (rsp_valid_out != '0) begin
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got hot %0h expected no response", rsp_valid_out);
      end else begin
        e_rsp = exp_rsp.pop_front();
        chk("rsp_hot", {124'b0, rsp_valid_out}, {124'b0, e_rsp.hot});
        chk("rsp_payload", {64'b0, rsp_payload_out}, {64'b0, e_rsp.pay});
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req_valid_in = '0;
    cache_prog_full_in = 1'b0;
    cache_rsp_valid_in = 1'b0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Present one response this cycle and expect it routed next cycle.
  task automatic send_rsp(int id, logic [RSW-1:0] pay);
    rsp_t r;
    cache_rsp_valid_in   = 1'b1;
    cache_rsp_id_in      = ID_W'(id);
    cache_rsp_payload_in = pay;
    r.hot = NUM_REQ'(1) << id;
    r.pay = pay;
    exp_rsp.push_back(r);
    tick();
    cache_rsp_valid_in = 1'b0;
  endtask

  task automatic exp_issue(int id);
    req_t r;
    r.id  = ID_W'(id);
    r.pay = pay_of(id);
    exp_req.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge ap_clk);
    chk("reset_outstanding", 128'(outstanding_out), 128'd0);
    chk("reset_error", 128'(error_out), 128'd0);
    chk("reset_done", 128'(done_out), 128'd1);
    chk("reset_ready", 128'(req_ready_out), 128'd0);

    // Single requester 2.
    tick();
    req_valid_in = 4'b0100;
    exp_issue(2);
    @(negedge ap_clk);
    chk("single_ready", 128'(req_ready_out), 128'h4);
    tick();
    req_valid_in = '0;
    @(negedge ap_clk);
    chk("single_outstanding", 128'(outstanding_out), 128'd1);
    chk("single_done_low", 128'(done_out), 128'd0);
    tick();
    send_rsp(2, 64'h11);

    // All four requesters until the in-flight cap.
    do_reset();
    req_valid_in = 4'b1111;
    for (int g = 0; g < 16; g++) begin
      exp_issue(g % 4);
      @(negedge ap_clk);
      chk("rr_ready", 128'(req_ready_out), 128'(1 << (g % 4)));
      tick();
    end
    @(negedge ap_clk);
    chk("full_ready", 128'(req_ready_out), 128'd0);
    chk("full_outstanding", 128'(outstanding_out), 128'd16);
    tick();
    @(negedge ap_clk);
    chk("full_hold", 128'(outstanding_out), 128'd16);

    // Response at the cap frees exactly one slot from the next cycle.
    tick();
    cache_rsp_valid_in   = 1'b1;
    cache_rsp_id_in      = 2'd1;
    cache_rsp_payload_in = 64'h22;
    exp_rsp.push_back('{hot: 4'b0010, pay: 64'h22});
    @(negedge ap_clk);
    chk("cap_rsp_ready", 128'(req_ready_out), 128'd0);
    tick();
    cache_rsp_valid_in = 1'b0;
    exp_issue(0);
    @(negedge ap_clk);
    chk("cap_outstanding", 128'(outstanding_out), 128'd15);
    chk("cap_regrant", 128'(req_ready_out), 128'h1);
    tick();
    @(negedge ap_clk);
    chk("cap_again_ready", 128'(req_ready_out), 128'd0);
    chk("cap_again_cnt", 128'(outstanding_out), 128'd16);
    tick();
    req_valid_in = '0;
    for (int k = 0; k < 11; k++) send_rsp(k % 4, 64'(k + 'h100));
    @(negedge ap_clk);
    chk("drain_to_5", 128'(outstanding_out), 128'd5);

    // Simultaneous transfer and response.
    tick();
    req_valid_in         = 4'b0010;
    cache_rsp_valid_in   = 1'b1;
    cache_rsp_id_in      = 2'd3;
    cache_rsp_payload_in = 64'h33;
    exp_issue(1);
    exp_rsp.push_back('{hot: 4'b1000, pay: 64'h33});
    @(negedge ap_clk);
    chk("simul_ready", 128'(req_ready_out), 128'h2);
    tick();
    req_valid_in = '0;
    cache_rsp_valid_in = 1'b0;
    @(negedge ap_clk);
    chk("simul_outstanding", 128'(outstanding_out), 128'd5);
    tick();
    for (int k = 0; k < 5; k++) send_rsp(k % 4, 64'(k + 'h200));
    @(negedge ap_clk);
    chk("drain_to_0", 128'(outstanding_out), 128'd0);

    // Backpressure from the cache request FIFO.
    do_reset();
    cache_prog_full_in = 1'b1;
    req_valid_in = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk("pfull_ready", 128'(req_ready_out), 128'd0);
      tick();
    end
    cache_prog_full_in = 1'b0;
    exp_issue(0);
    @(negedge ap_clk);
    chk("pfull_first", 128'(req_ready_out), 128'h1);
    tick();
    req_valid_in = 4'b1000;
    exp_issue(3);
    @(negedge ap_clk);
    chk("pfull_second", 128'(req_ready_out), 128'h8);
    tick();
    req_valid_in = '0;
    cache_prog_full_in = 1'b1;
    @(negedge ap_clk);
    chk("pfull_cnt", 128'(outstanding_out), 128'd2);
    tick();
    cache_prog_full_in = 1'b0;
    send_rsp(0, 64'h300);
    send_rsp(3, 64'h301);

    // Underflow sets the sticky error.
    send_rsp(2, 64'h44);
    @(negedge ap_clk);
    chk("uflow_error", 128'(error_out), 128'd1);
    chk("uflow_cnt", 128'(outstanding_out), 128'd0);
    chk("uflow_done_low", 128'(done_out), 128'd0);
    tick();
    @(negedge ap_clk);
    chk("idle_done", 128'(done_out), 128'd1);
    chk("sticky_error", 128'(error_out), 128'd1);
    tick();
    do_reset();
    @(negedge ap_clk);
    chk("reset_clears_error", 128'(error_out), 128'd0);
    chk("reset_done_again", 128'(done_out), 128'd1);

    tick();
    tick();
    chk("req_queue_empty", 128'(exp_req.size()), 128'd0);
    chk("rsp_queue_empty", 128'(exp_rsp.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
